// File: rtl/seven_bit_adder_pkg.sv
// Shared types, constants and decode helpers for the seven-bit adder load sequencer.
package seven_bit_adder_pkg;

  localparam int OP_W  = 7;
  localparam int NIB_W = 4;
  localparam int PH_W  = 2;
  localparam int TMR_W = 16;

  localparam logic [PH_W-1:0] PH_A_LO = 2'd0;
  localparam logic [PH_W-1:0] PH_A_HI = 2'd1;
  localparam logic [PH_W-1:0] PH_B_LO = 2'd2;
  localparam logic [PH_W-1:0] PH_B_HI = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [NIB_W-1:0] phase_nibble(input logic [PH_W-1:0] idx,
                                                    input logic [OP_W-1:0] a,
                                                    input logic [OP_W-1:0] b);
    logic [NIB_W-1:0] nib;
    case (idx)
      PH_A_LO: nib = a[3:0];
      PH_A_HI: nib = {1'b0, a[6:4]};
      PH_B_LO: nib = b[3:0];
      PH_B_HI: nib = {1'b0, b[6:4]};
      default: nib = 4'd0;
    endcase
    return nib;
  endfunction

  function automatic logic [3:0] phase_strobe(input logic [PH_W-1:0] idx);
    logic [3:0] pb;
    case (idx)
      PH_A_LO: pb = 4'b0001;
      PH_A_HI: pb = 4'b0010;
      PH_B_LO: pb = 4'b0100;
      PH_B_HI: pb = 4'b1000;
      default: pb = 4'b0000;
    endcase
    return pb;
  endfunction

endpackage

// File: rtl/seven_bit_adder_driver_phase_timer.sv
// Loadable down-counter; expire_o flags the last cycle of a loaded interval.
module phase_timer
  import seven_bit_adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Next count: reload wins, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 16'd1);

endmodule

// File: rtl/seven_bit_adder_driver.sv
// Drives two 7-bit operands into the seven-bit adder as four PB strobe phases
// and registers the expected sum/carry for a downstream checker.
module seven_bit_adder_driver
  import seven_bit_adder_pkg::*;
#(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] op_a,
  input  logic [OP_W-1:0] op_b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            PB1,
  output logic            PB2,
  output logic            PB3,
  output logic            PB4,
  output logic [NIB_W-1:0] a,
  output logic [OP_W-1:0] exp_sum,
  output logic            exp_cout
);

  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYCLES);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYCLES);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   idx_q, idx_d;
  logic [OP_W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [OP_W-1:0]   sum_q, sum_d;
  logic              cout_q, cout_d;
  logic [NIB_W-1:0]  a_q, a_d;
  logic [3:0]        pb_q, pb_d;
  logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic              tmr_load_s;
  logic [TMR_W-1:0]  tmr_val_s;
  logic              tmr_expire_s;

  phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .expire_o   (tmr_expire_s)
  );

  // Sequencer next-state, operand capture and timer loading.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = 16'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d         = ST_SETUP;
          idx_d           = PH_A_LO;
          opa_d           = op_a;
          opb_d           = op_b;
          {cout_d, sum_d} = {1'b0, op_a} + {1'b0, op_b};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d    = ST_PULSE;
        tmr_load_s = 1'b1;
        tmr_val_s  = PULSE_LD;
      end
      ST_PULSE: begin
        if (!tmr_expire_s) begin
          state_d = ST_PULSE;
        end else if (GAP_CYCLES > 0) begin
          state_d    = ST_GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LD;
        end else if (idx_q == PH_B_HI) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETUP;
          idx_d   = idx_q + 2'd1;
        end
      end
      ST_GAP: begin
        if (!tmr_expire_s) begin
          state_d = ST_GAP;
        end else if (idx_q == PH_B_HI) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETUP;
          idx_d   = idx_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    pb_d    = 4'b0000;
    a_d     = a_q;
    if (state_d == ST_PULSE) begin
      pb_d = phase_strobe(idx_d);
    end else begin
      pb_d = 4'b0000;
    end
    if (state_d == ST_SETUP) begin
      a_d = phase_nibble(idx_d, opa_d, opb_d);
    end else begin
      a_d = a_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= PH_A_LO;
      opa_q   <= 7'd0;
      opb_q   <= 7'd0;
      sum_q   <= 7'd0;
      cout_q  <= 1'b0;
      a_q     <= 4'd0;
      pb_q    <= 4'b0000;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      pb_q    <= pb_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign PB1      = pb_q[0];
  assign PB2      = pb_q[1];
  assign PB3      = pb_q[2];
  assign PB4      = pb_q[3];
  assign a        = a_q;
  assign exp_sum  = sum_q;
  assign exp_cout = cout_q;

endmodule

// File: tb/tb_seven_bit_adder_driver.sv
// Randomized self-checking bench: default-timing instance plus a PULSE=1/GAP=0 corner instance.
module tb_seven_bit_adder_driver;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic [6:0] op_a, op_b;

  logic       ready0, busy0, done0, pb1_0, pb2_0, pb3_0, pb4_0, cout0;
  logic [3:0] a0;
  logic [6:0] sum0;
  logic       ready1, busy1, done1, pb1_1, pb2_1, pb3_1, pb4_1, cout1;
  logic [3:0] a1;
  logic [6:0] sum1;

  int n_checks = 0;
  int n_errors = 0;

  seven_bit_adder_driver #(.PULSE_CYCLES(2), .GAP_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op_a(op_a), .op_b(op_b),
    .ready(ready0), .busy(busy0), .done(done0),
    .PB1(pb1_0), .PB2(pb2_0), .PB3(pb3_0), .PB4(pb4_0),
    .a(a0), .exp_sum(sum0), .exp_cout(cout0)
  );

  seven_bit_adder_driver #(.PULSE_CYCLES(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a), .op_b(op_b),
    .ready(ready1), .busy(busy1), .done(done1),
    .PB1(pb1_1), .PB2(pb2_1), .PB3(pb3_1), .PB4(pb4_1),
    .a(a1), .exp_sum(sum1), .exp_cout(cout1)
  );

  logic [3:0] pbv0, pbv1;
  assign pbv0 = {pb4_0, pb3_0, pb2_0, pb1_0};
  assign pbv1 = {pb4_1, pb3_1, pb2_1, pb1_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Nibble shown for phase ph, straight from the operand values.
  function automatic int ref_nibble(input int ph, input int av, input int bv);
    case (ph)
      0: return av % 16;
      1: return av / 16;
      2: return bv % 16;
      default: return bv / 16;
    endcase
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_pb0", pbv0, 0);
      check("idle_done0", done0, 0);
      check("idle_ready0", ready0, 1);
      check("idle_pb1", pbv1, 0);
      check("idle_ready1", ready1, 1);
    end
  endtask

  // One operand load on instance sel, checked cycle by cycle against a timing model.
  task automatic run_seq(input bit sel, input int av, input int bv, input bit inject);
    int p, g, len, tot, s, ph, pos, exp_pb;
    p   = sel ? 1 : 2;
    g   = sel ? 0 : 1;
    len = 1 + p + g;
    tot = 4 * len;
    s   = av + bv;
    op_a = 7'(av);
    op_b = 7'(bv);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    for (int t = 1; t <= tot + 2; t++) begin
      @(negedge clk);
      ph  = (t - 1) / len;
      if (ph > 3) ph = 3;
      pos = (t - 1) % len;
      exp_pb = (t <= tot && pos >= 1 && pos <= p) ? (1 << ph) : 0;
      check(sel ? "pb_c" : "pb", sel ? pbv1 : pbv0, exp_pb);
      check(sel ? "a_c" : "a", sel ? a1 : a0, ref_nibble(ph, av, bv));
      check(sel ? "done_c" : "done", sel ? done1 : done0, (t == tot + 1) ? 1 : 0);
      check(sel ? "ready_c" : "ready", sel ? ready1 : ready0, (t == tot + 2) ? 1 : 0);
      if (t <= tot || t == tot + 2)
        check(sel ? "busy_c" : "busy", sel ? busy1 : busy0, (t <= tot) ? 1 : 0);
      check(sel ? "sum_c" : "sum", sel ? sum1 : sum0, s % 128);
      check(sel ? "cout_c" : "cout", sel ? cout1 : cout0, s / 128);
      if (t == 1) begin
        start0 = 1'b0;
        start1 = 1'b0;
        op_a = 7'($urandom_range(0, 127));
        op_b = 7'($urandom_range(0, 127));
      end
      if (inject && t == 2 * len + 2) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      if (inject && t == 2 * len + 3) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; op_a = 7'd0; op_b = 7'd0;
    @(negedge clk);
    check("rst_ready", ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pb", pbv0, 0);
    check("rst_a", a0, 0);
    check("rst_sum", sum0, 0);
    check("rst_cout", cout0, 0);
    check("rst_ready_c", ready1, 1);
    rst_n = 1'b1;
    idle_cycles(20);
    check("idle_a", a0, 0);
    check("idle_sum", sum0, 0);

    run_seq(1'b0, 5, 9, 1'b0);
    idle_cycles(2);
    run_seq(1'b0, 127, 127, 1'b0);
    idle_cycles(2);
    run_seq(1'b0, 37, 100, 1'b1);
    idle_cycles(4);
    for (int i = 0; i < 6; i++) begin
      run_seq(1'b0, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), i[0]);
      idle_cycles(1 + (i % 2));
    end

    run_seq(1'b1, 5, 9, 1'b0);
    idle_cycles(1);
    run_seq(1'b1, 127, 127, 1'b1);
    idle_cycles(2);
    for (int i = 0; i < 3; i++) begin
      run_seq(1'b1, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), 1'b0);
      idle_cycles(1);
    end

    // Async reset in the middle of the PB3 strobe.
    op_a = 7'd10; op_b = 7'd20;
    start0 = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (t == 1) start0 = 1'b0;
    end
    check("pre_rst_pb3", pbv0, 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_pb", pbv0, 0);
    check("async_ready", ready0, 1);
    check("async_busy", busy0, 0);
    check("async_a", a0, 0);
    check("async_sum", sum0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    run_seq(1'b0, 64, 63, 1'b0);
    idle_cycles(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
